// File: rtl/idexe_hazard_reg.sv
// ID/EXE pipeline register with load-use bubble insertion, branch flush and global hold.
// Define HAZ_STATS_EN to add saturating stall/flush statistics counters.
module idexe_hazard_reg #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [XLEN-1:0]   IFID_pc_i,
  input  logic [4:0]        IFID_rs1_i,
  input  logic [4:0]        IFID_rs2_i,
  input  logic [4:0]        IFID_rd_i,
  input  logic [XLEN-1:0]   IFID_rs1data_i,
  input  logic [XLEN-1:0]   IFID_rs2data_i,
  input  logic [XLEN-1:0]   IFID_imm_i,
  input  logic [3:0]        IFID_funct_i,
  input  logic [CTRL_W-1:0] IFID_ctrl_i,
  input  logic              hold_i,
  input  logic              flush_i,
  output logic [XLEN-1:0]   IDEXE_pc_o,
  output logic [4:0]        IDEXE_rs1_o,
  output logic [4:0]        IDEXE_rs2_o,
  output logic [4:0]        IDEXE_rd_o,
  output logic [XLEN-1:0]   IDEXE_rs1data_o,
  output logic [XLEN-1:0]   IDEXE_rs2data_o,
  output logic [XLEN-1:0]   IDEXE_imm_o,
  output logic [3:0]        IDEXE_funct_o,
  output logic [CTRL_W-1:0] IDEXE_ctrl_o,
`ifdef HAZ_STATS_EN
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o,
`endif
  output logic              PCWrite_o,
  output logic              IFIDWrite_o,
  output logic              IFIDFlush_o,
  output logic              loaduse_o
);

  logic ex_mem_read;
  logic rd_nonzero;
  logic rd_matches;
  logic bubble;
  logic fetch_en;

  // Both rs fields are compared regardless of format; a false stall only costs a cycle.
  always_comb begin
    ex_mem_read = IDEXE_ctrl_o[1];
    rd_nonzero  = (IDEXE_rd_o != 5'd0);
    rd_matches  = (IDEXE_rd_o == IFID_rs1_i) || (IDEXE_rd_o == IFID_rs2_i);
    loaduse_o   = ex_mem_read && rd_nonzero && rd_matches;
  end

  // A flush overrides a pending load-use stall because the stalled instruction is on the wrong path.
  always_comb begin
    bubble      = flush_i || loaduse_o;
    fetch_en    = !hold_i && (flush_i || !loaduse_o);
    PCWrite_o   = fetch_en;
    IFIDWrite_o = fetch_en;
    IFIDFlush_o = flush_i && !hold_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      IDEXE_pc_o      <= '0;
      IDEXE_rs1_o     <= '0;
      IDEXE_rs2_o     <= '0;
      IDEXE_rd_o      <= '0;
      IDEXE_rs1data_o <= '0;
      IDEXE_rs2data_o <= '0;
      IDEXE_imm_o     <= '0;
      IDEXE_funct_o   <= '0;
      IDEXE_ctrl_o    <= '0;
    end else if (!hold_i) begin
      IDEXE_pc_o      <= IFID_pc_i;
      IDEXE_rs1_o     <= IFID_rs1_i;
      IDEXE_rs2_o     <= IFID_rs2_i;
      IDEXE_rs1data_o <= IFID_rs1data_i;
      IDEXE_rs2data_o <= IFID_rs2data_i;
      IDEXE_imm_o     <= IFID_imm_i;
      IDEXE_funct_o   <= IFID_funct_i;
      if (bubble) begin
        IDEXE_rd_o   <= '0;
        IDEXE_ctrl_o <= '0;
      end else begin
        IDEXE_rd_o   <= IFID_rd_i;
        IDEXE_ctrl_o <= IFID_ctrl_i;
      end
    end
  end

`ifdef HAZ_STATS_EN
  logic stall_evt;
  logic flush_evt;

  always_comb begin
    stall_evt = loaduse_o && !flush_i && !hold_i;
    flush_evt = flush_i && !hold_i;
  end

  // Counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_evt && (stall_cnt_o != {CNT_W{1'b1}}))
        stall_cnt_o <= stall_cnt_o + 1'b1;
      if (flush_evt && (flush_cnt_o != {CNT_W{1'b1}}))
        flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end
`endif

endmodule
